adc108s102_spi_ctrl: RTL and testbench
======================================

// Module: adc108s102_spi_ctrl
// PURPOSE
//  SPI master for the ADC108S102 (8-ch, 10-bit). Runs one 16-SCLK frame per start pulse.
//  Drives channel address on DIN and shifts in the 10-bit result from DOUT.
//  Presents data/data_ch with a one-cycle valid pulse.
//  Sits directly upstream of the 4-digit 7-segment display driver; data feeds its value input.
// PARAMETERS
//  CLK_DIV  4  clk_sample cycles per SCLK half-period (>=2); also the CS setup length
//  QUIET    8  clk_sample cycles with cs_n high after a frame before busy drops (>=1)
// PORTS
//  clk_sample  in   1   block clock; all logic on rising edge
//  rst_n       in   1   reset, asynchronous, active-low
//  start       in   1   request one conversion frame; ignored while busy
//  channel     in   3   channel to address in this frame; sampled when start is accepted
//  busy        out  1   high from the cycle after start is accepted until return to IDLE
//  adc_cs_n    out  1   ADC chip select, active-low
//  adc_sclk    out  1   ADC serial clock; idles high
//  adc_din     out  1   control bits to ADC; changes only on SCLK falling edges
//  adc_dout    in   1   data from ADC; sampled on SCLK rising edges
//  data        out  10  last conversion result
//  data_ch     out  3   channel that data belongs to
//  valid       out  1   one-cycle pulse when data/data_ch update
// BEHAVIOUR
//  - Reset (any time, incl. mid-frame): IDLE, cs_n=1, sclk=1, din=0, busy=0, valid=0, data=0,
//    data_ch=0, prev_ch=0, bit counter=0, divider=0. A partial frame is discarded.
//  - FSM: IDLE -> SETUP -> SHIFT -> DONE -> QUIET -> IDLE.
//  - IDLE: start=1 latches channel into cur_ch; next state SETUP.
//  - SETUP: CLK_DIV cycles; cs_n=0, sclk=1; din = frame bit 15 (0).
//  - SHIFT: 16 bits, index b=15..0. Per bit: sclk low CLK_DIV cycles, then high CLK_DIV cycles.
//  - Frame bit b is driven on din at the falling edge.
//  - DOUT is sampled in the clk_sample cycle where sclk goes 0->1 and shifted in MSB-first.
//  - DIN frame bits: 13=cur_ch[2], 12=cur_ch[1], 11=cur_ch[0]; all other bits 0.
//  - DOUT frame: bits 15..12 are zero; 11..2 are D9..D0; 1..0 are zero.
//    Leading/trailing bits are not checked.
//  - DONE (1 cycle): cs_n=1, sclk=1, din=0, valid=1, data=shift[11:2], data_ch=prev_ch,
//    then prev_ch<=cur_ch. The ADC returns the channel addressed in the previous frame.
//    The first frame after reset reports ch 0.
//  - QUIET: QUIET cycles, cs_n=1; then IDLE. A start during QUIET/DONE is dropped, not queued.
//  - busy is high for exactly 33*CLK_DIV+1+QUIET cycles per frame.
//  - data/data_ch hold between valid pulses.
//  - Back-to-back: start held high restarts in the first IDLE cycle (one IDLE cycle between frames).
//  - adc_dout needs no synchronizer: it is launched by the SCLK this block generates.
// CONFIGURATION
//  ADC_AVG4_EN defined:
//  - Each result is summed into a 12-bit accumulator.
//  - After 4 consecutive results with the same data_ch: valid pulses, data=acc[11:2] (truncating), acc clears.
//  - A result whose data_ch differs from the running channel clears the count and restarts
//    accumulation with that result; no valid.
//  - Reset clears acc/count.
//  ADC_AVG4_EN undefined: every DONE pulses valid with the raw result (as above).
// TESTING (CLK_DIV=2, QUIET=4, bus-functional ADC model)
//  1. Reset, then start with ch=5; model returns 0x2AB.
//     -> din bits 13..11 = 1,0,1; valid after 71 cycles total busy; data=model ch0 value; data_ch=0.
//  2. Second start with ch=3 -> data=0x2AB, data_ch=5; din bits 13..11 = 0,1,1.
//  3. Pulse start while busy -> no extra frame; cs_n low for exactly 1 frame; busy count unchanged.
//  4. Assert rst_n low mid-SHIFT (bit 7) -> same cycle: cs_n=1, sclk=1, busy=0.
//     -> Next frame data_ch=0; no valid pulse for the aborted frame.
//  5. Hold start high for 3 frames, ch=7, model returns 0x3FF then 0x000.
//     -> 3 valid pulses, one IDLE cycle between frames; data sequence per pipeline rule.
//  6. ADC_AVG4_EN: 5 frames on ch=2 returning 100,101,102,103
//     -> one valid (after first pipeline frame) with data=101, data_ch=2.

Source files
------------

// File: rtl/adc108s102_spi_ctrl.sv
// adc108s102_spi_ctrl: SPI master for the ADC108S102; one 16-SCLK frame per accepted start, result with a 1-cycle valid pulse.
// Latency: busy for 33*CLK_DIV+1+QUIET cycles; valid pulses 33*CLK_DIV+1 cycles after start is accepted.
// Backpressure: none; start is ignored (dropped, not queued) while busy. Option ADC_AVG4_EN: average 4 same-channel results.
module adc108s102_spi_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int QUIET   = 8
) (
  input  logic       clk_sample,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] channel,
  output logic       busy,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_din,
  input  logic       adc_dout,
  output logic [9:0] data,
  output logic [2:0] data_ch,
  output logic       valid
);

  localparam int CNT_MAX = (CLK_DIV > QUIET) ? CLK_DIV : QUIET;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_QUIET
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic             phase_q, phase_d;   // SCLK level inside SHIFT: 0 = low half, 1 = high half
  logic [2:0]       cur_ch_q, cur_ch_d;
  logic [2:0]       prev_ch_q;
  logic [9:0]       shift_q;            // only frame bits 11..2 (D9..D0) are captured
  logic             sample;
  logic             finish;
  logic             cs_n_d, sclk_d, din_d;

`ifdef ADC_AVG4_EN
  logic [11:0] acc_q;
  logic [1:0]  avg_cnt_q;
  logic [2:0]  avg_ch_q;
  logic [11:0] avg_sum;
  assign avg_sum = acc_q + {2'b00, shift_q};
`endif

  // Control bit for frame position b: channel address sits in bits 13..11.
  function automatic logic din_bit(input logic [2:0] ch, input logic [3:0] b);
    case (b)
      4'd13:   din_bit = ch[2];
      4'd12:   din_bit = ch[1];
      4'd11:   din_bit = ch[0];
      default: din_bit = 1'b0;
    endcase
  endfunction

  // Next-state, counter and next-pin-value logic.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    cur_ch_d = cur_ch_q;
    sample   = 1'b0;
    finish   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_ch_d = channel;
          div_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_q == CNT_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          bit_d   = 4'd15;
          phase_d = 1'b0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (div_q == CNT_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!phase_q) begin
            // SCLK rises at this edge: capture DOUT if it carries a data bit.
            phase_d = 1'b1;
            sample  = (bit_q <= 4'd11) && (bit_q >= 4'd2);
          end else if (bit_q == 4'd0) begin
            state_d = S_DONE;
            finish  = 1'b1;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q - 4'd1;
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        div_d   = '0;
        state_d = S_QUIET;
      end
      S_QUIET: begin
        if (div_q == CNT_W'(QUIET - 1)) begin
          div_d   = '0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Pins are registered from the next state so they are glitch-free off-chip.
    cs_n_d = !((state_d == S_SETUP) || (state_d == S_SHIFT));
    sclk_d = (state_d == S_SHIFT) ? phase_d : 1'b1;
    din_d  = (state_d == S_SHIFT) ? din_bit(cur_ch_d, bit_d) : 1'b0;
  end

  // FSM state and frame counters.
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      cur_ch_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      cur_ch_q <= cur_ch_d;
    end
  end

  // Registered ADC pins and busy flag.
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
      adc_din  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      adc_cs_n <= cs_n_d;
      adc_sclk <= sclk_d;
      adc_din  <= din_d;
      busy     <= (state_d != S_IDLE);
    end
  end

  // Capture DOUT and publish results; the ADC answers for the previous frame's channel.
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      prev_ch_q <= '0;
      data      <= '0;
      data_ch   <= '0;
      valid     <= 1'b0;
`ifdef ADC_AVG4_EN
      acc_q     <= '0;
      avg_cnt_q <= '0;
      avg_ch_q  <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if (sample) begin
        shift_q <= {shift_q[8:0], adc_dout};
      end
      if (finish) begin
        prev_ch_q <= cur_ch_q;
`ifdef ADC_AVG4_EN
        if ((avg_cnt_q == 2'd0) || (prev_ch_q != avg_ch_q)) begin
          // New run: this result is the first of up to four.
          acc_q     <= {2'b00, shift_q};
          avg_cnt_q <= 2'd1;
          avg_ch_q  <= prev_ch_q;
        end else if (avg_cnt_q == 2'd3) begin
          valid     <= 1'b1;
          data      <= avg_sum[11:2];
          data_ch   <= prev_ch_q;
          acc_q     <= '0;
          avg_cnt_q <= 2'd0;
        end else begin
          acc_q     <= avg_sum;
          avg_cnt_q <= avg_cnt_q + 2'd1;
        end
`else
        valid   <= 1'b1;
        data    <= shift_q;
        data_ch <= prev_ch_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_adc108s102_spi_ctrl.sv
// Testbench for adc108s102_spi_ctrl (CLK_DIV=2, QUIET=4) with a bus-functional ADC.
// A frame-position model (cycle offset k since accept) predicts every output each cycle.
// Directed cases pin literal values; a randomized phase exercises starts, data and resets.
module tb_adc108s102_spi_ctrl;
  localparam int CD        = 2;
  localparam int QT        = 4;
  localparam int DONE_K    = 33 * CD + 1;
  localparam int FRAME_LEN = DONE_K + QT;

  logic       clk_sample = 1'b0;
  logic       rst_n      = 1'b0;
  logic       start      = 1'b0;
  logic [2:0] channel    = 3'd0;
  logic       adc_dout   = 1'b0;
  logic       busy, adc_cs_n, adc_sclk, adc_din, valid;
  logic [9:0] data;
  logic [2:0] data_ch;

  int tests = 0;
  int fails = 0;

  always #5 clk_sample = ~clk_sample;

  adc108s102_spi_ctrl #(.CLK_DIV(CD), .QUIET(QT)) dut (
    .clk_sample(clk_sample), .rst_n(rst_n), .start(start), .channel(channel),
    .busy(busy), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din),
    .adc_dout(adc_dout), .data(data), .data_ch(data_ch), .valid(valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- bus-functional ADC ----------------
  logic [9:0]  adc_val [8];
  logic [2:0]  adc_prev_ch = 3'd0;
  logic [9:0]  adc_sent    = 10'd0;
  logic [15:0] adc_tx      = 16'd0;
  logic [15:0] din_sr      = 16'd0;
  int          adc_bit     = 0;
  int          din_n       = 0;
  int          cs_falls    = 0;

  always @(negedge adc_cs_n) begin
    adc_sent = adc_val[adc_prev_ch];
    adc_tx   = {4'b0000, adc_sent, 2'b00};
    adc_bit  = 15;
    din_sr   = 16'd0;
    din_n    = 0;
    adc_dout = 1'b0;
    cs_falls++;
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0 && adc_bit >= 0) begin
      adc_dout = adc_tx[adc_bit];
      adc_bit--;
    end
  end

  always @(posedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      din_sr = {din_sr[14:0], adc_din};
      din_n++;
      if (din_n == 5) adc_prev_ch = din_sr[2:0];
    end
  end

  // ---------------- behavioural reference ----------------
  int         k = 0;        // cycles since accept; 0 = idle
  logic [2:0] m_cur = 0, m_prev = 0, m_ch = 0;
  logic [9:0] m_data = 0;
  logic       m_valid = 0;
  int         a_acc = 0, a_cnt = 0;
  logic [2:0] a_ch = 0;

  always @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; m_cur = 0; m_prev = 0; m_ch = 0; m_data = 0; m_valid = 0;
      a_acc = 0; a_cnt = 0; a_ch = 0;
    end else begin
      m_valid = 0;
      if (k == 0) begin
        if (start === 1'b1) begin k = 1; m_cur = channel; end
      end else if (k == FRAME_LEN) begin
        k = 0;
      end else begin
        k++;
      end
      if (k == DONE_K) begin
`ifdef ADC_AVG4_EN
        if (a_cnt == 0 || m_prev != a_ch) begin
          a_acc = int'(adc_sent); a_cnt = 1; a_ch = m_prev;
        end else begin
          a_acc = a_acc + int'(adc_sent);
          a_cnt++;
          if (a_cnt == 4) begin
            m_valid = 1; m_data = 10'(a_acc / 4); m_ch = m_prev; a_acc = 0; a_cnt = 0;
          end
        end
`else
        m_valid = 1; m_data = adc_sent; m_ch = m_prev;
`endif
        m_prev = m_cur;
      end
    end
  end

  // Per-cycle comparison of every output against the reference.
  always @(negedge clk_sample) begin
    int   off, b;
    logic e_sclk, e_din;
    e_sclk = 1'b1;
    e_din  = 1'b0;
    if (k > CD && k <= 33 * CD) begin
      off    = k - CD - 1;
      e_sclk = (off % (2 * CD)) >= CD;
      b      = 15 - off / (2 * CD);
      e_din  = (b >= 11 && b <= 13) ? m_cur[b - 11] : 1'b0;
    end
    chk("busy",    32'(busy),     32'(k != 0));
    chk("cs_n",    32'(adc_cs_n), 32'(!(k >= 1 && k <= 33 * CD)));
    chk("sclk",    32'(adc_sclk), 32'(e_sclk));
    chk("din",     32'(adc_din),  32'(e_din));
    chk("valid",   32'(valid),    32'(m_valid));
    chk("data",    32'(data),     32'(m_data));
    chk("data_ch", 32'(data_ch),  32'(m_ch));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_sample);
    #1;
  endtask

  task automatic run_frame(input logic [2:0] ch, output int nbusy, output int nvalid,
                           output logic [9:0] vd, output logic [2:0] vc);
    start = 1'b1; channel = ch;
    tick();
    start = 1'b0;
    nbusy = 0; nvalid = 0; vd = 0; vc = 0;
    while (busy && nbusy < 500) begin
      nbusy++;
      if (valid) begin nvalid++; vd = data; vc = data_ch; end
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int nb, nv, gaps;
    logic [9:0] vd;
    logic [2:0] vc;
    logic [9:0] seq_d [3];
    logic [2:0] seq_c [3];

    for (int i = 0; i < 8; i++) adc_val[i] = 10'(32'h3A + i * 91);
    adc_val[0] = 10'h155;
    adc_val[5] = 10'h2AB;
    tick(); tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset cs_n", 32'(adc_cs_n), 32'd1);
    chk("reset sclk", 32'(adc_sclk), 32'd1);
    chk("reset data", 32'(data), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    tick();

`ifndef ADC_AVG4_EN
    // 1: first frame reports channel 0's sample.
    run_frame(3'd5, nb, nv, vd, vc);
    chk("t1 busy cycles", 32'(nb), 32'd71);
    chk("t1 valid count", 32'(nv), 32'd1);
    chk("t1 data", 32'(vd), 32'h155);
    chk("t1 data_ch", 32'(vc), 32'd0);
    chk("t1 din frame", 32'(din_sr), 32'h2800);
    // 2: pipeline returns the previous channel.
    run_frame(3'd3, nb, nv, vd, vc);
    chk("t2 data", 32'(vd), 32'h2AB);
    chk("t2 data_ch", 32'(vc), 32'd5);
    chk("t2 din frame", 32'(din_sr), 32'h1800);
    // 3: starts while busy are dropped.
    cs_falls = 0;
    start = 1'b1; channel = 3'd1;
    tick();
    start = 1'b0;
    nb = 0;
    while (busy && nb < 500) begin
      nb++;
      start = (nb == 10 || nb == 40 || nb == 67 || nb == 71);
      channel = 3'd6;
      tick();
    end
    start = 1'b0;
    tick(); tick(); tick();
    chk("t3 busy cycles", 32'(nb), 32'd71);
    chk("t3 cs frames", 32'(cs_falls), 32'd1);
    chk("t3 stays idle", 32'(busy), 32'd0);
    // 4: reset during bit 7 aborts the frame immediately.
    start = 1'b1; channel = 3'd6;
    tick();
    start = 1'b0;
    nv = 0;
    for (int i = 0; i < 35; i++) begin
      if (valid) nv++;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("t4 cs_n in reset", 32'(adc_cs_n), 32'd1);
    chk("t4 sclk in reset", 32'(adc_sclk), 32'd1);
    chk("t4 busy in reset", 32'(busy), 32'd0);
    chk("t4 no valid aborted", 32'(nv), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_frame(3'd4, nb, nv, vd, vc);
    chk("t4 next data_ch", 32'(vc), 32'd0);
    chk("t4 next valid count", 32'(nv), 32'd1);
    // 5: start held high for three back-to-back frames.
    adc_val[4] = 10'h3FF;
    adc_val[7] = 10'h000;
    start = 1'b1; channel = 3'd7;
    tick();
    nv = 0; gaps = 0;
    for (int i = 0; i < 3 * FRAME_LEN + 2; i++) begin
      if (valid && nv < 3) begin seq_d[nv] = data; seq_c[nv] = data_ch; end
      if (valid) nv++;
      if (!busy) gaps++;
      tick();
    end
    start = 1'b0;
    chk("t5 valid count", 32'(nv), 32'd3);
    chk("t5 idle gaps", 32'(gaps), 32'd2);
    chk("t5 data0", 32'(seq_d[0]), 32'h3FF);
    chk("t5 ch0", 32'(seq_c[0]), 32'd4);
    chk("t5 data1", 32'(seq_d[1]), 32'h000);
    chk("t5 ch1", 32'(seq_c[1]), 32'd7);
    chk("t5 data2", 32'(seq_d[2]), 32'h000);
    tick();
    chk("t5 idle after", 32'(busy), 32'd0);
`else
    // 6: four same-channel results averaged into one pulse.
    adc_val[0] = 10'd7;
    gaps = 0;
    for (int f = 0; f < 5; f++) begin
      if (f >= 1) adc_val[2] = 10'(99 + f);
      run_frame(3'd2, nb, nv, vd, vc);
      gaps += nv;
      if (f == 4) begin
        chk("t6 data", 32'(vd), 32'd101);
        chk("t6 data_ch", 32'(vc), 32'd2);
        chk("t6 last frame valid", 32'(nv), 32'd1);
      end
    end
    chk("t6 total valid", 32'(gaps), 32'd1);
`endif

    // Randomized: random starts (also while busy), data changes and rare resets.
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 5) == 0);
      channel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 40) == 0) adc_val[$urandom_range(0, 7)] = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 700) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    start = 1'b0;
    for (int i = 0; i < FRAME_LEN + 4; i++) tick();
    chk("final idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
